cu_vertex_cache_fill_module: RTL and testbench

Fill-side companion of the PageRank PULL vertex cache. It tracks read commands that missed the cache and went to memory, collects the returning response and two half-cacheline data beats, and extracts the requested vertex word. It then emits an `EdgeDataCache` fill record that writes the cache arrays and feeds the compute unit. It sits between the miss-command output of the vertex cache and the read response/data return path of the CU.

---
 rtl/cu_vertex_cache_fill_module.sv | 271 +++++++++++++++++++++++++++
 tb/tb_cu_vertex_cache_fill_module.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/cu_vertex_cache_fill_module.sv
// cu_vertex_cache_fill_module
// Fill side of the PageRank PULL vertex cache. Misses issued to memory are
// tracked in an in-order FIFO of vertex ids; the returning response and the two
// half-cacheline data beats are collected (any order, any cycles) and the
// requested vertex word is extracted into an EdgeDataCache fill record.
// Optional feature: define VERTEX_FILL_ORDER_CHECK_EN to compare the latched
// response address against the FIFO head and drop mismatching fills.

package cu_vertex_cache_fill_pkg;
    localparam int DATA_SIZE_READ_BITS        = 32;
    localparam int CACHELINE_DATA_READ_NUM_HF = 16;
    localparam int VERTEX_ID_BITS             = 32;

    typedef struct packed {
        logic [VERTEX_ID_BITS-1:0] address_offset;
    } CommandBufferCmd;

    typedef struct packed {
        CommandBufferCmd cmd;
    } CommandBufferPayload;

    typedef struct packed {
        logic                valid;
        CommandBufferPayload payload;
    } CommandBufferLine;

    typedef struct packed {
        logic                valid;
        CommandBufferPayload payload;
    } ResponseBufferLine;

    // Element 0 occupies the least significant DATA_SIZE_READ_BITS bits.
    typedef logic [CACHELINE_DATA_READ_NUM_HF-1:0][DATA_SIZE_READ_BITS-1:0] HalfLineData;

    typedef struct packed {
        HalfLineData data;
    } ReadWriteDataPayload;

    typedef struct packed {
        logic                valid;
        ReadWriteDataPayload payload;
    } ReadWriteDataLine;

    typedef struct packed {
        logic [VERTEX_ID_BITS-1:0]      id;
        logic [DATA_SIZE_READ_BITS-1:0] data;
    } EdgeDataPayload;

    typedef struct packed {
        logic           valid;
        EdgeDataPayload payload;
    } EdgeDataCache;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        EMIT
    } fill_state_e;
endpackage

module cu_vertex_cache_fill_module
    import cu_vertex_cache_fill_pkg::*;
#(
    parameter int FILL_FIFO_DEPTH    = 16,
    parameter int FILL_FIFO_PTR_BITS = $clog2(FILL_FIFO_DEPTH)
) (
    input  logic                        clock,
    input  logic                        rstn_in,
    input  logic                        enabled_in,
    input  CommandBufferLine            read_command_in,
    input  ResponseBufferLine           read_response_in,
    input  ReadWriteDataLine            read_data_0_in,
    input  ReadWriteDataLine            read_data_1_in,
    output EdgeDataCache                edge_data_variable_out,
    output logic [FILL_FIFO_PTR_BITS:0] outstanding_count_out,
    output logic                        overflow_out,
    output logic                        underflow_out
);

    localparam int                            CNT_W     = FILL_FIFO_PTR_BITS + 1;
    localparam logic [CNT_W-1:0]              DEPTH_CNT = CNT_W'(FILL_FIFO_DEPTH);
    localparam logic [FILL_FIFO_PTR_BITS-1:0] PTR_ONE   = FILL_FIFO_PTR_BITS'(1);
    localparam int                            LANE_BITS = $clog2(CACHELINE_DATA_READ_NUM_HF);

    logic rstn_internal;

    logic              enabled_q;
    CommandBufferLine  cmd_q;
    ResponseBufferLine resp_q;
    ReadWriteDataLine  data0_q;
    ReadWriteDataLine  data1_q;

    logic [VERTEX_ID_BITS-1:0] fifo_mem [FILL_FIFO_DEPTH];

    fill_state_e                   state_q, state_d;
    logic [FILL_FIFO_PTR_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [FILL_FIFO_PTR_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]              count_q, count_d;
    logic                          held_d0_q, held_d0_d;
    logic                          held_d1_q, held_d1_d;
    logic                          held_resp_q, held_resp_d;
    HalfLineData                   line0_q, line0_d;
    HalfLineData                   line1_q, line1_d;
    logic                          overflow_q, overflow_d;
    logic                          underflow_q, underflow_d;
    EdgeDataCache                  edge_q, edge_d;
    logic                          fill_ok;

    logic                           fifo_empty;
    logic                           fifo_full;
    logic                           push;
    logic                           pop;
    logic                           resp_orphan;
    logic [VERTEX_ID_BITS-1:0]      head;
    logic [LANE_BITS-1:0]           fill_lane;
    logic [DATA_SIZE_READ_BITS-1:0] fill_word;

`ifdef VERTEX_FILL_ORDER_CHECK_EN
    logic [VERTEX_ID_BITS-1:0] resp_addr_q, resp_addr_d;
`else
    logic unused_resp_payload;
    assign unused_resp_payload = ^resp_q.payload;
`endif

    // Re-register the external reset; its assertion still propagates at once.
    always_ff @(posedge clock or negedge rstn_in) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rstn_in) rstn_internal <= 1'b0;
        else          rstn_internal <= 1'b1;
    end

    // Input stage: every port is registered once before use.
    always_ff @(posedge clock or negedge rstn_internal) begin
        if (!rstn_internal) begin
            enabled_q <= 1'b0;
            cmd_q     <= '0;
            resp_q    <= '0;
            data0_q   <= '0;
            data1_q   <= '0;
        end else begin
            enabled_q <= enabled_in;
            cmd_q     <= read_command_in;
            resp_q    <= read_response_in;
            data0_q   <= read_data_0_in;
            data1_q   <= read_data_1_in;
        end
    end

    // Tracking FIFO storage; occupancy lives in the pointers and count.
    always_ff @(posedge clock) begin
        // NOTE: storage has no reset; entries are only ever read after being written.
        if (push) fifo_mem[wr_ptr_q] <= cmd_q.payload.cmd.address_offset;
    end

    assign fifo_empty  = (count_q == '0);
    assign fifo_full   = (count_q == DEPTH_CNT);
    assign pop         = (state_q == EMIT);
    assign push        = cmd_q.valid && (!fifo_full || pop);
    assign head        = fifo_mem[rd_ptr_q];
    assign fill_lane   = head[LANE_BITS-1:0];
    assign fill_word   = head[LANE_BITS] ? line1_q[fill_lane] : line0_q[fill_lane];
    // A response with no entry left for it (the popped head is already spoken for).
    assign resp_orphan = resp_q.valid && (pop ? (count_q == CNT_W'(1)) : fifo_empty);

    // Next-state logic for FIFO, beat collection, assembly FSM and fill output.
    always_comb begin
        // NOTE: defaults first so no branch leaves a variable unassigned (no latches).
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        line0_d     = line0_q;
        line1_d     = line1_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        edge_d      = edge_q;
        edge_d.valid = 1'b0;
        fill_ok     = 1'b0;
`ifdef VERTEX_FILL_ORDER_CHECK_EN
        resp_addr_d = resp_addr_q;
`endif

        if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        if (cmd_q.valid && !push) overflow_d = 1'b1;

        // EMIT consumes the held set; beats latched in the same cycle start the next one.
        held_d0_d   = (held_d0_q && !pop) || data0_q.valid;
        held_d1_d   = (held_d1_q && !pop) || data1_q.valid;
        held_resp_d = (held_resp_q && !pop) || resp_q.valid;
        if (data0_q.valid) line0_d = data0_q.payload.data;
        if (data1_q.valid) line1_d = data1_q.payload.data;
`ifdef VERTEX_FILL_ORDER_CHECK_EN
        if (resp_q.valid) resp_addr_d = resp_q.payload.cmd.address_offset;
`endif

        if (resp_orphan) begin
            underflow_d = 1'b1;
            held_d0_d   = 1'b0;
            held_d1_d   = 1'b0;
            held_resp_d = 1'b0;
            state_d     = IDLE;
        end else if (pop) begin
            state_d = (held_d0_d || held_d1_d || held_resp_d) ? COLLECT : IDLE;
        end else if (held_d0_d && held_d1_d && held_resp_d && !fifo_empty) begin
            state_d = EMIT;
        end else if (held_d0_d || held_d1_d || held_resp_d) begin
            state_d = COLLECT;
        end

        if (pop) begin
            fill_ok = enabled_q;
`ifdef VERTEX_FILL_ORDER_CHECK_EN
            if (resp_addr_q != head) begin
                fill_ok     = 1'b0;
                underflow_d = 1'b1;
            end
`endif
            if (fill_ok) begin
                edge_d.valid        = 1'b1;
                edge_d.payload.id   = head;
                edge_d.payload.data = fill_word;
            end
        end
    end

    // Assembly FSM, FIFO bookkeeping, held beats and registered outputs.
    always_ff @(posedge clock or negedge rstn_internal) begin
        if (!rstn_internal) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            held_d0_q   <= 1'b0;
            held_d1_q   <= 1'b0;
            held_resp_q <= 1'b0;
            line0_q     <= '0;
            line1_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            edge_q      <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            held_d0_q   <= held_d0_d;
            held_d1_q   <= held_d1_d;
            held_resp_q <= held_resp_d;
            line0_q     <= line0_d;
            line1_q     <= line1_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            edge_q      <= edge_d;
        end
    end

`ifdef VERTEX_FILL_ORDER_CHECK_EN
    // Latched response address used for the in-order check at EMIT.
    always_ff @(posedge clock or negedge rstn_internal) begin
        if (!rstn_internal) resp_addr_q <= '0;
        else                resp_addr_q <= resp_addr_d;
    end
`endif

    assign edge_data_variable_out = edge_q;
    assign outstanding_count_out  = count_q;
    assign overflow_out           = overflow_q;
    assign underflow_out          = underflow_q;

endmodule

// File: tb/tb_cu_vertex_cache_fill_module.sv
// Directed bench for cu_vertex_cache_fill_module: reset, basic and
// out-of-order fills, enable gating, overflow/drain, underflow, mid-run reset.
module tb_cu_vertex_cache_fill_module;
    import cu_vertex_cache_fill_pkg::*;

    logic              clock;
    logic              rstn_in;
    logic              enabled_in;
    CommandBufferLine  read_command_in;
    ResponseBufferLine read_response_in;
    ReadWriteDataLine  read_data_0_in;
    ReadWriteDataLine  read_data_1_in;
    EdgeDataCache      edge_data_variable_out;
    logic [4:0]        outstanding_count_out;
    logic              overflow_out;
    logic              underflow_out;

    int checks = 0;
    int errors = 0;

    cu_vertex_cache_fill_module #(
        .FILL_FIFO_DEPTH(16)
    ) dut (
        .clock                 (clock),
        .rstn_in               (rstn_in),
        .enabled_in            (enabled_in),
        .read_command_in       (read_command_in),
        .read_response_in      (read_response_in),
        .read_data_0_in        (read_data_0_in),
        .read_data_1_in        (read_data_1_in),
        .edge_data_variable_out(edge_data_variable_out),
        .outstanding_count_out (outstanding_count_out),
        .overflow_out          (overflow_out),
        .underflow_out         (underflow_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Advance one clock; everything is driven and sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_cmd(input logic [31:0] offset);
        read_command_in.valid                      = 1'b1;
        read_command_in.payload.cmd.address_offset = offset;
        tick();
        read_command_in = '0;
    endtask

    task automatic send_beats(input logic [31:0] id, input logic r, input logic d0, input logic d1);
        read_response_in.valid                      = r;
        read_response_in.payload.cmd.address_offset = id;
        read_data_0_in.valid                        = d0;
        read_data_1_in.valid                        = d1;
        tick();
        read_response_in.valid = 1'b0;
        read_data_0_in.valid   = 1'b0;
        read_data_1_in.valid   = 1'b0;
    endtask

    // Called right after the last beat was latched: fill appears two edges later, for one cycle.
    task automatic expect_fill(input string tag, input logic [31:0] id, input logic [31:0] data);
        tick();
        check({tag, "_early"}, edge_data_variable_out.valid, 1'b0);
        tick();
        check({tag, "_valid"}, edge_data_variable_out.valid, 1'b1);
        check({tag, "_id"}, edge_data_variable_out.payload.id, id);
        check({tag, "_data"}, edge_data_variable_out.payload.data, data);
        tick();
        check({tag, "_pulse"}, edge_data_variable_out.valid, 1'b0);
    endtask

    initial begin
        rstn_in          = 1'b0;
        enabled_in       = 1'b1;
        read_command_in  = '0;
        read_response_in = '0;
        read_data_0_in   = '0;
        read_data_1_in   = '0;
        for (int i = 0; i < 16; i++) begin
            read_data_0_in.payload.data[i] = 32'hAAAA_0000 + 32'(i);
            read_data_1_in.payload.data[i] = 32'hBBBB_0010 + 32'(i);
        end
        repeat (3) tick();

        // Reset state
        check("rst_valid", edge_data_variable_out.valid, 1'b0);
        check("rst_payload", edge_data_variable_out.payload, 64'h0);
        check("rst_count", outstanding_count_out, 5'd0);
        check("rst_overflow", overflow_out, 1'b0);
        check("rst_underflow", underflow_out, 1'b0);
        rstn_in = 1'b1;
        repeat (2) tick();

        // Basic fill: 0x25 -> idx 5 in the lower half
        send_cmd(32'h25);
        check("basic_count_lat1", outstanding_count_out, 5'd0);
        tick();
        check("basic_count_lat2", outstanding_count_out, 5'd1);
        send_beats(32'h25, 1'b1, 1'b1, 1'b1);
        expect_fill("basic", 32'h25, 32'hAAAA_0005);
        check("basic_count_after", outstanding_count_out, 5'd0);

        // Basic fill: 0x35 -> idx 21, element 5 of the upper half
        send_cmd(32'h35);
        tick();
        send_beats(32'h35, 1'b1, 1'b1, 1'b1);
        expect_fill("upper", 32'h35, 32'hBBBB_0015);

        // Out-of-order beats: data_1 at t, response at t+4, data_0 at t+7
        read_data_0_in.payload.data[3] = 32'h0000_1234;
        send_cmd(32'h03);
        tick();
        send_beats(32'h03, 1'b0, 1'b0, 1'b1);
        repeat (3) tick();
        send_beats(32'h03, 1'b1, 1'b0, 1'b0);
        tick();
        check("ooo_no_early", edge_data_variable_out.valid, 1'b0);
        tick();
        send_beats(32'h03, 1'b0, 1'b1, 1'b0);
        expect_fill("ooo", 32'h03, 32'h0000_1234);
        read_data_0_in.payload.data[3] = 32'hAAAA_0003;

        // Enable low: the fill is popped but never shown
        enabled_in = 1'b0;
        send_cmd(32'h10);
        tick();
        check("en_count_in", outstanding_count_out, 5'd1);
        send_beats(32'h10, 1'b1, 1'b1, 1'b1);
        tick();
        tick();
        check("en_suppressed", edge_data_variable_out.valid, 1'b0);
        check("en_count_out", outstanding_count_out, 5'd0);
        tick();
        check("en_suppressed_late", edge_data_variable_out.valid, 1'b0);
        enabled_in = 1'b1;
        tick();
        send_cmd(32'h3E);
        tick();
        send_beats(32'h3E, 1'b1, 1'b1, 1'b1);
        expect_fill("reenable", 32'h3E, 32'hBBBB_001E);

        // Overflow: 17 commands back-to-back, the 17th (0x50) is dropped
        for (int i = 0; i < 17; i++) send_cmd(32'h40 + 32'(i));
        tick();
        check("ovf_count", outstanding_count_out, 5'd16);
        check("ovf_flag", overflow_out, 1'b1);
        check("ovf_no_underflow", underflow_out, 1'b0);

        // Drain: fills come back for 0x40..0x4F in issue order
        for (int i = 0; i < 16; i++) begin
            send_beats(32'h40 + 32'(i), 1'b1, 1'b1, 1'b1);
            tick();
            tick();
            check("drain_valid", edge_data_variable_out.valid, 1'b1);
            check("drain_id", edge_data_variable_out.payload.id, 32'h40 + 32'(i));
            check("drain_data", edge_data_variable_out.payload.data, 32'hAAAA_0000 + 32'(i));
            tick();
        end
        check("drain_count", outstanding_count_out, 5'd0);

        // Underflow: full beat set with an empty FIFO (0x50 has no entry)
        send_beats(32'h50, 1'b1, 1'b1, 1'b1);
        tick();
        check("unf_no_fill_a", edge_data_variable_out.valid, 1'b0);
        tick();
        check("unf_no_fill_b", edge_data_variable_out.valid, 1'b0);
        check("unf_flag", underflow_out, 1'b1);
        check("unf_count", outstanding_count_out, 5'd0);

        // Reset mid-operation with only data_0 held
        send_cmd(32'h07);
        tick();
        send_beats(32'h07, 1'b0, 1'b1, 1'b0);
        tick();
        check("mid_count_before", outstanding_count_out, 5'd1);
        rstn_in = 1'b0;
        #1;
        check("mid_rst_valid", edge_data_variable_out.valid, 1'b0);
        check("mid_rst_payload", edge_data_variable_out.payload, 64'h0);
        check("mid_rst_count", outstanding_count_out, 5'd0);
        check("mid_rst_overflow", overflow_out, 1'b0);
        check("mid_rst_underflow", underflow_out, 1'b0);
        repeat (2) tick();
        rstn_in = 1'b1;
        repeat (2) tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_rst_quiet", edge_data_variable_out.valid, 1'b0);
        end
        send_cmd(32'h07);
        tick();
        send_beats(32'h07, 1'b1, 1'b1, 1'b1);
        expect_fill("post_rst", 32'h07, 32'hAAAA_0007);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_rst_once", edge_data_variable_out.valid, 1'b0);
        end
        check("post_rst_count", outstanding_count_out, 5'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
